// File: rtl/systolic_drain.sv
// systolic_drain: deskews systolic-array column sums into whole vectors and buffers them in a valid/ready FIFO.
// Define SYSTOLIC_DRAIN_ACCUM_EN to add per-column saturating accumulation across acc_last-delimited groups.

package Config;
   localparam int unsigned sys_rows   = 4;
   localparam int unsigned sys_cols   = 4;
   localparam int unsigned P_BITWIDTH = 16;
endpackage

module systolic_drain
   import Config::*;
#(
   parameter int unsigned LAT_BASE   = sys_rows,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                row_valid,
   input  logic                                acc_last,
   input  logic [sys_cols-1:0][P_BITWIDTH-1:0] of_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [sys_cols-1:0][P_BITWIDTH-1:0] out_data,
   output logic                                feed_ok,
   output logic                                overflow
);

   localparam int unsigned TAG_LEN = LAT_BASE + sys_cols - 1;
   localparam int unsigned AW      = $clog2(FIFO_DEPTH);
   localparam int unsigned PW      = AW + 1;
   localparam int unsigned CW      = $clog2(TAG_LEN + FIFO_DEPTH + 2) + 1;

   typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] vec_t;

   logic [TAG_LEN-1:0] tag_v;
   logic               tag_out;
   vec_t               aligned;
   vec_t               push_vec;
   logic               push_req;

   // Tag pipeline: a vector's tag emerges on the cycle its last column is sampled
   always_ff @(posedge clk or negedge rst) begin : tag_pipe
      if (!rst) tag_v <= '0;
      else      tag_v <= TAG_LEN'({tag_v, row_valid});
   end

   assign tag_out = tag_v[TAG_LEN-1];

   // Column j arrives j cycles late, so it is held back sys_cols-1-j cycles
   for (genvar j = 0; j < sys_cols; j++) begin : g_col
      localparam int unsigned D = sys_cols - 1 - j;
      if (D == 0) begin : g_pass
         assign aligned[j] = of_data[j];
      end else begin : g_dly
         logic [D*P_BITWIDTH-1:0] dl;
         always_ff @(posedge clk or negedge rst) begin : dly_line
            if (!rst) dl <= '0;
            else      dl <= (D*P_BITWIDTH)'({dl, of_data[j]});
         end
         assign aligned[j] = dl[D*P_BITWIDTH-1 -: P_BITWIDTH];
      end
   end

`ifdef SYSTOLIC_DRAIN_ACCUM_EN
   localparam logic [P_BITWIDTH-1:0] SMAX = {1'b0, {(P_BITWIDTH-1){1'b1}}};
   localparam logic [P_BITWIDTH-1:0] SMIN = {1'b1, {(P_BITWIDTH-1){1'b0}}};

   logic [TAG_LEN-1:0] last_v;
   logic               tag_last;
   vec_t               acc;
   vec_t               sum;

   always_ff @(posedge clk or negedge rst) begin : last_pipe
      if (!rst) last_v <= '0;
      else      last_v <= TAG_LEN'({last_v, row_valid && acc_last});
   end

   assign tag_last = last_v[TAG_LEN-1];

   // One guard bit detects signed overflow; clamp to the representable range
   for (genvar j = 0; j < sys_cols; j++) begin : g_sat
      logic [P_BITWIDTH:0] wide;
      assign wide   = {acc[j][P_BITWIDTH-1], acc[j]} + {aligned[j][P_BITWIDTH-1], aligned[j]};
      assign sum[j] = (wide[P_BITWIDTH] != wide[P_BITWIDTH-1]) ?
                      (wide[P_BITWIDTH] ? SMIN : SMAX) : wide[P_BITWIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin : acc_regs
      if (!rst)         acc <= '0;
      else if (tag_out) acc <= tag_last ? '0 : sum;
   end

   assign push_req = tag_out && tag_last;
   assign push_vec = sum;
`else
   logic unused_acc_last;
   assign unused_acc_last = acc_last;
   assign push_req        = tag_out;
   assign push_vec        = aligned;
`endif

   vec_t          mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, wr_next, rd_next, count, count_next;
   logic          full, pop, push, drop;
   logic [CW-1:0] in_flight, in_flight_next;
   vec_t          head_next;

   // A full FIFO still takes a push when the consumer pops in the same cycle
   always_comb begin : fifo_ctl
      count          = wr_ptr - rd_ptr;
      full           = (count == PW'(FIFO_DEPTH));
      pop            = out_valid && out_ready;
      push           = push_req && (!full || pop);
      drop           = push_req && !push;
      wr_next        = wr_ptr + PW'(push);
      rd_next        = rd_ptr + PW'(pop);
      count_next     = wr_next - rd_next;
      in_flight_next = in_flight + CW'(row_valid) - CW'(tag_out);
      head_next      = mem[rd_next[AW-1:0]];
      if (push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) head_next = push_vec;
   end

   // Head of the FIFO is mirrored into out_data so it only moves on a pop or a push into empty
   always_ff @(posedge clk or negedge rst) begin : fifo_regs
      if (!rst) begin
         mem       <= '{default: '0};
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         in_flight <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         feed_ok   <= 1'b1;
         overflow  <= 1'b0;
      end else begin
         if (push) mem[wr_ptr[AW-1:0]] <= push_vec;
         wr_ptr    <= wr_next;
         rd_ptr    <= rd_next;
         in_flight <= in_flight_next;
         out_valid <= (count_next != '0);
         out_data  <= (count_next != '0) ? head_next : '0;
         feed_ok   <= (in_flight_next + CW'(count_next)) < CW'(FIFO_DEPTH);
         overflow  <= overflow | drop;
      end
   end

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: a bench-side array model skews of_data per column, expectations are hand-derived.
module tb_systolic_drain;
   import Config::*;

   localparam int unsigned LAT   = sys_rows;
   localparam int unsigned DEPTH = 4;

   typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] vec_t;

   typedef struct {
      logic rv;
      logic rdy;
      int   base;
      logic ev;
      int   ebase;
      logic efo;
   } rec_t;

   logic clk       = 1'b0;
   logic rst       = 1'b0;
   logic row_valid = 1'b0;
   logic acc_last  = 1'b0;
   logic out_ready = 1'b0;
   vec_t of_data   = '0;
   logic out_valid;
   vec_t out_data;
   logic feed_ok;
   logic overflow;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic hist_valid [64];
   vec_t hist_v     [64];
   rec_t tbl        [22];

   systolic_drain #(.LAT_BASE(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .row_valid(row_valid), .acc_last(acc_last),
      .of_data(of_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .feed_ok(feed_ok), .overflow(overflow)
   );

   always #5 clk = ~clk;

   function automatic vec_t ramp(input int base);
      vec_t v;
      for (int j = 0; j < sys_cols; j++) v[j] = P_BITWIDTH'(base + j);
      return v;
   endfunction

   function automatic vec_t flat(input int x);
      vec_t v;
      for (int j = 0; j < sys_cols; j++) v[j] = P_BITWIDTH'(x);
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic clear_hist();
      cyc = 0;
      for (int i = 0; i < 64; i++) hist_valid[i] = 1'b0;
   endtask

   // Records this cycle's issue and presents column j of the vector issued LAT+j cycles ago
   task automatic drive(input logic rv, input logic last, input vec_t v, input logic rdy);
      hist_valid[cyc % 64] = rv;
      hist_v[cyc % 64]     = v;
      row_valid = rv;
      acc_last  = last;
      out_ready = rdy;
      for (int j = 0; j < sys_cols; j++) begin
         int src;
         src = cyc - int'(LAT) - j;
         if (src >= 0 && hist_valid[src % 64]) of_data[j] = hist_v[src % 64][j];
         else                                  of_data[j] = P_BITWIDTH'(16'hDEAD);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 22; i++)
         tbl[i] = '{rv: 1'b0, rdy: 1'b1, base: 0, ev: 1'b0, ebase: 0, efo: 1'b1};
      tbl[0].rv  = 1'b1; tbl[0].base  = 10;
      tbl[8].ev  = 1'b1; tbl[8].ebase = 10;
      tbl[10].rv = 1'b1; tbl[10].base = 20;
      tbl[11].rv = 1'b1; tbl[11].base = 40;
      tbl[12].rv = 1'b1; tbl[12].base = 60;
      tbl[18].ev = 1'b1; tbl[18].ebase = 20;
      tbl[19].ev = 1'b1; tbl[19].ebase = 40;
      tbl[20].ev = 1'b1; tbl[20].ebase = 60;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", int'(out_valid), 0);
      chk_vec("reset_out_data", out_data, '0);
      chk("reset_overflow", int'(overflow), 0);
      chk("reset_feed_ok", int'(feed_ok), 1);
      rst = 1'b1;
      step();

      // Single vector, then three back-to-back vectors
      clear_hist();
      for (int i = 0; i < 22; i++) begin
         drive(tbl[i].rv, tbl[i].rv, ramp(tbl[i].base), tbl[i].rdy);
         chk("tbl_out_valid", int'(out_valid), int'(tbl[i].ev));
         if (tbl[i].ev) chk_vec("tbl_out_data", out_data, ramp(tbl[i].ebase));
         chk("tbl_feed_ok", int'(feed_ok), int'(tbl[i].efo));
         step();
      end
      chk("tbl_overflow", int'(overflow), 0);

      // Full FIFO with consumer stalled: fifth vector dropped
      clear_hist();
      for (int c = 0; c <= 16; c++) begin
         drive(c < 5, c < 5, ramp(100 * (c + 1)), c >= 12);
         if (c == 3) chk("full_feed_ok_3", int'(feed_ok), 1);
         if (c == 4) chk("full_feed_ok_4", int'(feed_ok), 0);
         if (c == 11) begin
            chk("full_overflow_pre", int'(overflow), 0);
            chk("full_valid_stall", int'(out_valid), 1);
            chk_vec("full_data_stall", out_data, ramp(100));
         end
         if (c == 12) chk("full_overflow", int'(overflow), 1);
         if (c >= 12 && c <= 15) begin
            chk("full_drain_valid", int'(out_valid), 1);
            chk_vec("full_drain_data", out_data, ramp(100 * (c - 11)));
         end
         if (c == 16) begin
            chk("full_empty_valid", int'(out_valid), 0);
            chk("full_empty_feed_ok", int'(feed_ok), 1);
         end
         step();
      end

      // Reset asserted while a vector is in flight
      clear_hist();
      for (int c = 0; c <= 24; c++) begin
         if (c == 5) rst = 1'b0;
         if (c == 7) rst = 1'b1;
         drive(c == 0, c == 0, ramp(7), 1'b1);
         #1;
         if (c == 4) chk("mid_overflow_sticky", int'(overflow), 1);
         if (c == 5 || c == 6) begin
            chk("mid_rst_out_valid", int'(out_valid), 0);
            chk_vec("mid_rst_out_data", out_data, '0);
            chk("mid_rst_overflow", int'(overflow), 0);
            chk("mid_rst_feed_ok", int'(feed_ok), 1);
         end
         if (c >= 7) chk("mid_no_emerge", int'(out_valid), 0);
         if (c == 24) chk("mid_feed_ok", int'(feed_ok), 1);
         step();
      end

      // Full FIFO, push and pop on the same edge
      clear_hist();
      for (int c = 0; c <= 16; c++) begin
         drive(c < 5, c < 5, ramp(1000 + 100 * c), c >= 11);
         if (c == 11) begin
            chk("pp_valid", int'(out_valid), 1);
            chk_vec("pp_head", out_data, ramp(1000));
            chk("pp_feed_ok_11", int'(feed_ok), 0);
         end
         if (c == 12) begin
            chk("pp_overflow", int'(overflow), 0);
            chk("pp_feed_ok_12", int'(feed_ok), 0);
         end
         if (c >= 12 && c <= 15) begin
            chk("pp_drain_valid", int'(out_valid), 1);
            chk_vec("pp_drain_data", out_data, ramp(1000 + 100 * (c - 11)));
         end
         if (c == 16) begin
            chk("pp_empty_valid", int'(out_valid), 0);
            chk("pp_overflow_end", int'(overflow), 0);
         end
         step();
      end

`ifdef SYSTOLIC_DRAIN_ACCUM_EN
      // Accumulation over a three-vector group
      clear_hist();
      for (int c = 0; c <= 12; c++) begin
         drive(c < 3, c == 2, flat(2), 1'b1);
         if (c == 8 || c == 9 || c == 11) chk("acc_no_push", int'(out_valid), 0);
         if (c == 10) begin
            chk("acc_valid", int'(out_valid), 1);
            chk_vec("acc_sum", out_data, flat(6));
         end
         step();
      end

      // Positive saturation
      clear_hist();
      for (int c = 0; c <= 10; c++) begin
         drive(c < 2, c == 1, flat((1 << (P_BITWIDTH - 1)) - 1), 1'b1);
         if (c == 9) begin
            chk("sat_valid", int'(out_valid), 1);
            chk_vec("sat_data", out_data, flat((1 << (P_BITWIDTH - 1)) - 1));
         end
         if (c == 10) chk("sat_single", int'(out_valid), 0);
         step();
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
